output_wb_packer: RTL
=====================

Name: output_wb_packer

Overview:
- Writeback stage between the output scaler set and the activation buffer's internal write port.
- Latches one full scaled output vector (all banks) and emits it as a sequence of buffer-width words with incrementing byte addresses.
- Zero-masks channels beyond the configured channel count and skips fully inactive banks.
- Optionally packs 4-bit outputs two banks per word.

Parameters:
numBanks, 8, number of column banks in the output vector
numCols, 32, output channels per bank
elementBits, 8, bits per scaled output element
writeWidth, 256, activation buffer internal write width in bits (must equal numCols*elementBits)
addrWidth, 32, byte address width

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-high (asserted = 1 resets on the rising clk edge)
cfg_num_output_channels  in  16  active output channels for the current layer
cfg_output_bits  in  4  output precision; 4 or 8; other values treated as 8
data_i  in  numBanks*numCols*elementBits  scaled outputs; channel c occupies bits [c*elementBits +: elementBits]
addr_i  in  addrWidth  byte base address for the vector
valid_i  in  1  data_i/addr_i valid
ready_o  out  1  packer can accept a vector
wr_data_o  out  writeWidth  write data to buffer
wr_addr_o  out  addrWidth  byte write address
wr_en_o  out  1  write strobe
wr_stall_i  in  1  buffer cannot accept a write this cycle
busy_o  out  1  vector held and not fully written

Behaviour:
- Reset values: ready_o=1, wr_en_o=0, wr_data_o=0, wr_addr_o=0, busy_o=0. The holding register and counters clear.
- Reset mid-DRAIN aborts the vector with no further writes. Reset dominates valid_i.
- Handshake: a vector is accepted on a cycle with valid_i&&ready_o. On acceptance:
  - data_i, addr_i, cfg_num_output_channels and cfg_output_bits are captured.
  - Config changes during DRAIN have no effect on the current vector.
- Word count:
  - 8-bit mode: C = min(cfg_num_output_channels, numBanks*numCols); W = ceil(C/numCols).
  - 4-bit mode: W = ceil(C/(2*numCols)).
- FSM IDLE: ready_o=1. On acceptance with W>0, go to DRAIN. On acceptance with W=0, stay in IDLE with no writes.
- FSM DRAIN: ready_o=0, busy_o=1. Word index k runs 0..W-1.
  - Each cycle with wr_stall_i=0: assert wr_en_o, drive word k, wr_addr_o = base + k*(writeWidth/8), then k++.
  - Each cycle with wr_stall_i=1: wr_en_o=0 and k holds; data and address are don't-care.
  - After word W-1 is written, go to IDLE on the next cycle.
- Latency: first wr_en_o can occur at earliest in the cycle after acceptance. An unstalled vector takes W consecutive write cycles.
- ready_o returns 1 in the cycle after the last write, so the minimum spacing between accepted vectors is W+1 cycles.
- 8-bit word k = bank k channels [k*numCols +: numCols], each element full width.
- 4-bit word k = banks 2k (low half) and 2k+1 (high half):
  - Each element is truncated to its low 4 bits.
  - Channel j of the word occupies bits [j*4 +: 4].
  - If 2k+1 >= numBanks, the high half is zero.
- Masking: any element with global channel index >= C is driven as zero.
- Address arithmetic wraps modulo 2^addrWidth with no error.
- valid_i while ready_o=0: ignored. The source must hold data until ready.

Optional Feature:
- Macro QRACC_WB_NIBBLE_PACK_EN.
- Defined: 4-bit packing as described above.
- Undefined: cfg_output_bits is ignored, the packer always operates in 8-bit mode, and no 4-bit datapath is synthesized.

Test Plan:
- Reset then idle -> ready_o=1, wr_en_o=0, busy_o=0. Assert nrst=1 mid-DRAIN after 2 of 8 writes -> no further wr_en_o, ready_o=1 the cycle after reset.
- 8-bit, channels=256, addr=0x100, channel c value = c[7:0], no stall -> 8 writes on consecutive cycles starting 1 cycle after acceptance; addresses 0x100,0x120,...,0x1E0; word 3 byte 0 = 0x60. ready_o=1 one cycle after the last write.
- 8-bit, channels=40, all elements 0xFF -> 2 writes; word 0 all 0xFF; word 1 bytes 0..7 = 0xFF, bytes 8..31 = 0x00.
- 8-bit, channels=256, wr_stall_i=1 for cycles 2-4 of DRAIN -> still exactly 8 writes with no duplicated or skipped address; busy_o is high until the 8th write completes.
- With QRACC_WB_NIBBLE_PACK_EN: 4-bit, channels=100, all elements 0xA7 -> 2 writes at base and base+0x20:
  - word 0 is all nibbles 0x7;
  - word 1 is nibbles 0..35 = 0x7, rest 0.
- channels=0 with valid_i=1 -> accepted, zero writes, ready_o remains 1. The next vector is accepted on the following cycle.

Source files
------------

// File: rtl/output_wb_packer_if.sv
// Bus between the output scaler set and the writeback packer, plus the packer's
// write port into the activation buffer.
// master: the side that offers vectors and consumes writes.
// slave:  the packer.
interface output_wb_packer_if #(
  parameter int numBanks    = 8,
  parameter int numCols     = 32,
  parameter int elementBits = 8,
  parameter int writeWidth  = 256,
  parameter int addrWidth   = 32
);
  logic [15:0]                             cfg_num_output_channels;
  logic [3:0]                              cfg_output_bits;
  logic [numBanks*numCols*elementBits-1:0] data_i;
  logic [addrWidth-1:0]                    addr_i;
  logic                                    valid_i;
  logic                                    ready_o;
  logic [writeWidth-1:0]                   wr_data_o;
  logic [addrWidth-1:0]                    wr_addr_o;
  logic                                    wr_en_o;
  logic                                    wr_stall_i;
  logic                                    busy_o;

  modport slave (
    input  cfg_num_output_channels, cfg_output_bits, data_i, addr_i, valid_i, wr_stall_i,
    output ready_o, wr_data_o, wr_addr_o, wr_en_o, busy_o
  );

  modport master (
    output cfg_num_output_channels, cfg_output_bits, data_i, addr_i, valid_i, wr_stall_i,
    input  ready_o, wr_data_o, wr_addr_o, wr_en_o, busy_o
  );
endinterface

// File: rtl/output_wb_packer.sv
// Writeback packer: latches one scaled output vector (all banks) and streams it
// into the activation buffer as writeWidth-bit words at incrementing byte
// addresses. Channels at or beyond the configured count are written as zero and
// banks holding no active channel are never written.
// Optional feature macro: QRACC_WB_NIBBLE_PACK_EN enables 4-bit mode, where two
// banks are packed per word using the low nibble of each element. Without it the
// packer is 8-bit only and cfg_output_bits is ignored.
module output_wb_packer #(
  parameter int numBanks    = 8,
  parameter int numCols     = 32,
  parameter int elementBits = 8,
  parameter int writeWidth  = 256,
  parameter int addrWidth   = 32
) (
  input  logic                clk,
  input  logic                nrst,
  output_wb_packer_if.slave   bus
);

  localparam int totalCh      = numBanks * numCols;
  localparam int holdBits     = totalCh * elementBits;
  localparam int bytesPerWord = writeWidth / 8;
  localparam int idxWidth     = $clog2(numBanks + 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [holdBits-1:0]    holdData_q, holdData_d;
  logic [addrWidth-1:0]   baseAddr_q, baseAddr_d;
  logic [15:0]            numCh_q, numCh_d;
  logic [idxWidth-1:0]    wordIdx_q, wordIdx_d;
  logic [idxWidth-1:0]    wordCount_q, wordCount_d;

  logic                   accept;
  logic                   writeFire;
  logic                   lastWord;
  logic [15:0]            chClamp;
  logic [idxWidth-1:0]    wordsAtAccept;
  logic [writeWidth-1:0]  wordData;
  logic [addrWidth-1:0]   wordAddr;

`ifdef QRACC_WB_NIBBLE_PACK_EN
  logic                   nibbleSel;
  logic                   nibbleMode_q, nibbleMode_d;
`endif

  // Clamp the requested channel count to the vector size and work out how many
  // buffer words the incoming vector needs; a result of zero means nothing to write.
  always_comb begin
    chClamp = (bus.cfg_num_output_channels > 16'(totalCh)) ? 16'(totalCh)
                                                           : bus.cfg_num_output_channels;
`ifdef QRACC_WB_NIBBLE_PACK_EN
    nibbleSel = (bus.cfg_output_bits == 4'd4);
    if (nibbleSel)
      wordsAtAccept = idxWidth'((32'(chClamp) + 32'(2*numCols - 1)) / 32'(2*numCols));
    else
`endif
      wordsAtAccept = idxWidth'((32'(chClamp) + 32'(numCols - 1)) / 32'(numCols));
  end

  // FSM next state: IDLE accepts a vector, DRAIN emits one word per unstalled cycle.
  always_comb begin
    state_d   = state_q;
    wordIdx_d = wordIdx_q;
    accept    = 1'b0;
    writeFire = 1'b0;
    lastWord  = (wordIdx_q == (wordCount_q - idxWidth'(1)));
    case (state_q)
      IDLE: begin
        accept = bus.valid_i;
        if (accept) begin
          wordIdx_d = '0;
          if (wordsAtAccept != '0)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.wr_stall_i) begin
          writeFire = 1'b1;
          if (lastWord) begin
            state_d   = IDLE;
            wordIdx_d = '0;
          end else begin
            wordIdx_d = wordIdx_q + idxWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot the vector, base address and layer config at acceptance so that
  // later config changes cannot disturb a vector that is still draining.
  always_comb begin
    holdData_d  = holdData_q;
    baseAddr_d  = baseAddr_q;
    numCh_d     = numCh_q;
    wordCount_d = wordCount_q;
`ifdef QRACC_WB_NIBBLE_PACK_EN
    nibbleMode_d = nibbleMode_q;
`endif
    if (accept) begin
      holdData_d  = bus.data_i;
      baseAddr_d  = bus.addr_i;
      numCh_d     = chClamp;
      wordCount_d = wordsAtAccept;
`ifdef QRACC_WB_NIBBLE_PACK_EN
      nibbleMode_d = nibbleSel;
`endif
    end
  end

  // State and holding registers; reset abandons any vector in flight.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q     <= IDLE;
      holdData_q  <= '0;
      baseAddr_q  <= '0;
      numCh_q     <= '0;
      wordIdx_q   <= '0;
      wordCount_q <= '0;
`ifdef QRACC_WB_NIBBLE_PACK_EN
      nibbleMode_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      holdData_q  <= holdData_d;
      baseAddr_q  <= baseAddr_d;
      numCh_q     <= numCh_d;
      wordIdx_q   <= wordIdx_d;
      wordCount_q <= wordCount_d;
`ifdef QRACC_WB_NIBBLE_PACK_EN
      nibbleMode_q <= nibbleMode_d;
`endif
    end
  end

  // Build the current word from the held vector, zeroing channels past the
  // captured channel count; in 4-bit mode the word spans two adjacent banks.
  always_comb begin
    wordData = '0;
`ifdef QRACC_WB_NIBBLE_PACK_EN
    if (nibbleMode_q) begin
      for (int j = 0; j < 2*numCols; j++) begin
        if (((2*int'(wordIdx_q) + j/numCols) < numBanks) &&
            ((2*int'(wordIdx_q)*numCols + j) < int'(numCh_q)))
          wordData[j*4 +: 4] = holdData_q[(2*int'(wordIdx_q)*numCols + j)*elementBits +: 4];
      end
    end else
`endif
    begin
      for (int j = 0; j < numCols; j++) begin
        if ((int'(wordIdx_q)*numCols + j) < int'(numCh_q))
          wordData[j*elementBits +: elementBits] =
            holdData_q[(int'(wordIdx_q)*numCols + j)*elementBits +: elementBits];
      end
    end
  end

  // Byte address of the current word; wraps silently at the top of the space.
  always_comb begin
    wordAddr = baseAddr_q + addrWidth'(bytesPerWord) * addrWidth'(wordIdx_q);
  end

  assign bus.ready_o   = (state_q == IDLE);
  assign bus.busy_o    = (state_q == DRAIN);
  assign bus.wr_en_o   = writeFire && !nrst;
  assign bus.wr_data_o = (state_q == DRAIN) ? wordData : '0;
  assign bus.wr_addr_o = (state_q == DRAIN) ? wordAddr : '0;

endmodule
